data_collector_ctrl: RTL and testbench

Sequences and shares collection capture for G_NB_COLLECTOR sample sources feeding the testbench data-collector file writer.
- Each channel has a start/stop capture window with an optional sample limit, buffered in a per-channel FIFO.
- A round-robin arbiter merges all channels onto one tagged valid/ready stream consumed by the file-dump logic.
- Replaces per-channel free-running collection with controlled, backpressure-aware capture.

---
 rtl/data_collector_pkg.sv | 19 +
 rtl/collector_fifo.sv | 46 ++++
 rtl/data_collector_ctrl.sv | 148 ++++++++++++++
 tb/tb_data_collector_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/data_collector_pkg.sv
// Shared types and helpers for the data-collector capture controller.
package data_collector_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } ch_state_t;

    // Width of a channel index; a single channel still gets a 1-bit id.
    function automatic int id_width(input int nb_ch);
        return (nb_ch <= 1) ? 1 : $clog2(nb_ch);
    endfunction

    function automatic int fifo_addr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/collector_fifo.sv
// Per-channel synchronous first-word-fall-through FIFO; writes while full are discarded.
module collector_fifo
    import data_collector_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int AW = fifo_addr_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Extra pointer MSB distinguishes full from empty when the addresses match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en && !empty)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/data_collector_ctrl.sv
// Per-channel start/stop capture windows buffered in FIFOs, merged by a
// round-robin arbiter onto one tagged valid/ready stream.
module data_collector_ctrl
    import data_collector_pkg::*;
#(
    parameter int G_NB_COLLECTOR = 2,
    parameter int G_DATA_WIDTH   = 32,
    parameter int G_FIFO_DEPTH   = 8,
    parameter int G_CNT_WIDTH    = 16,
    localparam int IW = id_width(G_NB_COLLECTOR)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [G_NB_COLLECTOR-1:0]              i_start,
    input  logic [G_NB_COLLECTOR-1:0]              i_stop,
    input  logic [G_CNT_WIDTH-1:0]                 i_nb_samples,
    input  logic [G_NB_COLLECTOR-1:0]              i_valid,
    input  logic [G_NB_COLLECTOR*G_DATA_WIDTH-1:0] i_data,
    output logic                                   o_valid,
    output logic [G_DATA_WIDTH-1:0]                o_data,
    output logic [IW-1:0]                          o_id,
    input  logic                                   i_ready,
    output logic [G_NB_COLLECTOR-1:0]              o_busy,
    output logic [G_NB_COLLECTOR-1:0]              o_done,
    output logic [G_NB_COLLECTOR-1:0]              o_overflow
);

    localparam logic [G_CNT_WIDTH-1:0] CNT_ONE = G_CNT_WIDTH'(1);

    ch_state_t                 state [G_NB_COLLECTOR];
    logic [G_CNT_WIDTH-1:0]    count [G_NB_COLLECTOR];
    logic [G_CNT_WIDTH-1:0]    limit [G_NB_COLLECTOR];
    logic [G_DATA_WIDTH-1:0]   fifo_dout [G_NB_COLLECTOR];
    logic [G_NB_COLLECTOR-1:0] fifo_wr, fifo_rd, fifo_full, fifo_empty, holds_out;
    logic [IW-1:0]             rr_ptr, grant_idx, arb_idx;
    logic                      grant_any, load;

    for (genvar c = 0; c < G_NB_COLLECTOR; c++) begin : g_fifo
        collector_fifo #(
            .DEPTH(G_FIFO_DEPTH),
            .WIDTH(G_DATA_WIDTH)
        ) u_fifo (
            .clk  (clk),
            .rst  (rst),
            .wr_en(fifo_wr[c]),
            .din  (i_data[c*G_DATA_WIDTH +: G_DATA_WIDTH]),
            .full (fifo_full[c]),
            .rd_en(fifo_rd[c]),
            .dout (fifo_dout[c]),
            .empty(fifo_empty[c])
        );
    end

    assign load = !o_valid || i_ready;

    // Scan downward so the lowest offset from the RR pointer wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        arb_idx   = '0;
        for (int i = G_NB_COLLECTOR - 1; i >= 0; i--) begin
            arb_idx = IW'((int'(rr_ptr) + i) % G_NB_COLLECTOR);
            if (!fifo_empty[arb_idx]) begin
                grant_any = 1'b1;
                grant_idx = arb_idx;
            end
        end
    end

    always_comb begin
        fifo_wr   = '0;
        fifo_rd   = '0;
        holds_out = '0;
        for (int c = 0; c < G_NB_COLLECTOR; c++) begin
            fifo_wr[c]   = (state[c] == COLLECT) && i_valid[c];
            fifo_rd[c]   = load && grant_any && (grant_idx == IW'(c));
            holds_out[c] = o_valid && (o_id == IW'(c));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_id    <= '0;
            rr_ptr  <= '0;
        end else if (load) begin
            o_valid <= grant_any;
            if (grant_any) begin
                o_data <= fifo_dout[grant_idx];
                o_id   <= grant_idx;
                rr_ptr <= (grant_idx == IW'(G_NB_COLLECTOR - 1)) ? '0 : grant_idx + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < G_NB_COLLECTOR; c++) begin
                state[c] <= IDLE;
                count[c] <= '0;
                limit[c] <= '0;
            end
            o_busy     <= '0;
            o_done     <= '0;
            o_overflow <= '0;
        end else begin
            for (int c = 0; c < G_NB_COLLECTOR; c++) begin
                o_done[c] <= 1'b0;
                case (state[c])
                    IDLE: begin
                        if (i_start[c] && !i_stop[c]) begin
                            state[c]      <= COLLECT;
                            limit[c]      <= i_nb_samples;
                            count[c]      <= '0;
                            o_overflow[c] <= 1'b0;
                            o_busy[c]     <= 1'b1;
                        end
                    end
                    COLLECT: begin
                        // Dropped samples still count toward the limit; count saturates.
                        if (i_valid[c]) begin
                            if (count[c] != '1)
                                count[c] <= count[c] + CNT_ONE;
                            if (fifo_full[c])
                                o_overflow[c] <= 1'b1;
                        end
                        if (i_stop[c] || (i_valid[c] && (limit[c] != '0) &&
                                          ((count[c] + CNT_ONE) == limit[c])))
                            state[c] <= DRAIN;
                    end
                    DRAIN: begin
                        if (fifo_empty[c] && !holds_out[c]) begin
                            state[c]  <= IDLE;
                            o_busy[c] <= 1'b0;
                            o_done[c] <= 1'b1;
                        end
                    end
                    default: begin
                        state[c]  <= IDLE;
                        o_busy[c] <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_data_collector_ctrl.sv
// Directed bench for data_collector_ctrl: scoreboard of expected {id,data} transfers.
module tb_data_collector_ctrl;

    localparam int N  = 2;
    localparam int W  = 32;
    localparam int D  = 8;
    localparam int CW = 16;
    localparam int IW = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      i_start, i_stop, i_valid;
    logic [CW-1:0]     i_nb_samples;
    logic [N*W-1:0]    i_data;
    logic              o_valid;
    logic [W-1:0]      o_data;
    logic [IW-1:0]     o_id;
    logic              i_ready;
    logic [N-1:0]      o_busy, o_done, o_overflow;

    int                n_checks = 0;
    int                n_fail   = 0;
    int                done_cnt [N];
    logic [IW+W-1:0]   exp_q [$];
    logic [IW+W-1:0]   exp_word;

    data_collector_ctrl #(
        .G_NB_COLLECTOR(N),
        .G_DATA_WIDTH  (W),
        .G_FIFO_DEPTH  (D),
        .G_CNT_WIDTH   (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_stop      (i_stop),
        .i_nb_samples(i_nb_samples),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .o_id        (o_id),
        .i_ready     (i_ready),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_overflow  (o_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int id, input logic [W-1:0] d);
        exp_q.push_back({IW'(id), d});
    endtask

    task automatic clear_done();
        for (int c = 0; c < N; c++) done_cnt[c] = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        clear_done();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int cyc = 0;
        while ((o_busy != '0 || exp_q.size() != 0) && cyc < budget) begin
            tick(1);
            cyc++;
        end
        check(tag, 64'(cyc < budget), 64'd1);
    endtask

    // Monitor on the falling edge: score transfers and count done pulses.
    always @(negedge clk) begin
        if (!rst) begin
            for (int c = 0; c < N; c++)
                if (o_done[c]) done_cnt[c]++;
            if (o_valid && i_ready) begin
                check("xfer_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    exp_word = exp_q.pop_front();
                    check("xfer_id", 64'(o_id), 64'(exp_word[IW+W-1:W]));
                    check("xfer_data", 64'(o_data), 64'(exp_word[W-1:0]));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; i_start = '0; i_stop = '0; i_nb_samples = '0;
        i_valid = '0; i_data = '0; i_ready = 1'b0;
        clear_done();
        #12;
        check("rst_o_valid", 64'(o_valid), 64'd0);
        check("rst_o_data", 64'(o_data), 64'd0);
        check("rst_o_id", 64'(o_id), 64'd0);
        check("rst_o_busy", 64'(o_busy), 64'd0);
        check("rst_o_done", 64'(o_done), 64'd0);
        check("rst_o_overflow", 64'(o_overflow), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick(1);

        // Test 1: limit of 4 on ch0, six samples offered
        i_ready = 1'b1;
        i_nb_samples = 16'd4;
        i_start = 2'b01; tick(1); i_start = '0;
        check("t1_busy", 64'(o_busy), 64'b01);
        for (int k = 0; k < 6; k++) begin
            i_valid = 2'b01;
            i_data[W-1:0] = 32'h10 + 32'(k);
            if (k < 4) push_exp(0, 32'h10 + 32'(k));
            tick(1);
            if (k == 0) check("t1_lat_edge1", 64'(o_valid), 64'd0);
            if (k == 1) check("t1_lat_edge2", 64'(o_valid), 64'd1);
        end
        i_valid = '0;
        wait_idle("t1_idle_timeout", 40);
        tick(2);
        check("t1_done_cnt", 64'(done_cnt[0]), 64'd1);
        check("t1_overflow", 64'(o_overflow), 64'd0);
        check("t1_exp_left", 64'(exp_q.size()), 64'd0);

        // Test 2: both channels unlimited, interleaved round-robin
        do_reset();
        i_nb_samples = 16'd0;
        i_start = 2'b11; tick(1); i_start = '0;
        for (int k = 0; k < 4; k++) begin
            push_exp(0, 32'h20 + 32'(k));
            push_exp(1, 32'h30 + 32'(k));
        end
        for (int k = 0; k < 4; k++) begin
            i_valid = 2'b11;
            i_data = {32'h30 + 32'(k), 32'h20 + 32'(k)};
            tick(1);
        end
        i_valid = '0;
        i_stop = 2'b11; tick(1); i_stop = '0;
        wait_idle("t2_idle_timeout", 40);
        tick(2);
        check("t2_done_ch0", 64'(done_cnt[0]), 64'd1);
        check("t2_done_ch1", 64'(done_cnt[1]), 64'd1);
        check("t2_exp_left", 64'(exp_q.size()), 64'd0);

        // Test 3: ch1 overflow under backpressure
        clear_done();
        i_ready = 1'b0;
        i_start = 2'b10; tick(1); i_start = '0;
        for (int k = 0; k < 12; k++) begin
            i_valid = 2'b10;
            i_data[W +: W] = 32'h40 + 32'(k);
            tick(1);
            if (k == 8) check("t3_ovf_after_9", 64'(o_overflow), 64'b00);
            if (k == 9) check("t3_ovf_after_10", 64'(o_overflow), 64'b10);
        end
        i_valid = '0;
        check("t3_hold_valid", 64'(o_valid), 64'd1);
        check("t3_hold_data", 64'(o_data), 64'h40);
        check("t3_hold_id", 64'(o_id), 64'd1);
        for (int k = 0; k < 9; k++) push_exp(1, 32'h40 + 32'(k));
        i_ready = 1'b1;
        i_stop = 2'b10; tick(1); i_stop = '0;
        wait_idle("t3_idle_timeout", 60);
        tick(2);
        check("t3_done_ch1", 64'(done_cnt[1]), 64'd1);
        check("t3_exp_left", 64'(exp_q.size()), 64'd0);
        check("t3_ovf_sticky", 64'(o_overflow), 64'b10);

        // Test 4: start with stop in IDLE is ignored
        clear_done();
        i_start = 2'b01; i_stop = 2'b01; tick(1);
        i_start = '0; i_stop = '0;
        check("t4_busy", 64'(o_busy), 64'd0);
        tick(3);
        check("t4_no_done", 64'(done_cnt[0]), 64'd0);
        check("t4_no_valid", 64'(o_valid), 64'd0);

        // Test 5: stop coincident with the final limit sample
        clear_done();
        i_nb_samples = 16'd3;
        i_start = 2'b01; tick(1); i_start = '0;
        for (int k = 0; k < 4; k++) begin
            i_valid = 2'b01;
            i_data[W-1:0] = 32'h50 + 32'(k);
            i_stop = (k == 2) ? 2'b01 : 2'b00;
            if (k < 3) push_exp(0, 32'h50 + 32'(k));
            tick(1);
        end
        i_valid = '0; i_stop = '0;
        wait_idle("t5_idle_timeout", 40);
        tick(2);
        check("t5_done_cnt", 64'(done_cnt[0]), 64'd1);
        check("t5_exp_left", 64'(exp_q.size()), 64'd0);

        // Test 6: asynchronous reset in the middle of a capture
        clear_done();
        i_ready = 1'b0;
        i_nb_samples = 16'd0;
        i_start = 2'b01; tick(1); i_start = '0;
        for (int k = 0; k < 5; k++) begin
            i_valid = 2'b01;
            i_data[W-1:0] = 32'h60 + 32'(k);
            tick(1);
        end
        i_valid = '0;
        check("t6_pre_valid", 64'(o_valid), 64'd1);
        check("t6_pre_busy", 64'(o_busy), 64'b01);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_valid", 64'(o_valid), 64'd0);
        check("t6_rst_data", 64'(o_data), 64'd0);
        check("t6_rst_id", 64'(o_id), 64'd0);
        check("t6_rst_busy", 64'(o_busy), 64'd0);
        check("t6_rst_done", 64'(o_done), 64'd0);
        check("t6_rst_overflow", 64'(o_overflow), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        i_ready = 1'b1;
        tick(6);
        check("t6_post_valid", 64'(o_valid), 64'd0);
        check("t6_post_busy", 64'(o_busy), 64'd0);
        check("t6_no_done", 64'(done_cnt[0]), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
